id_ex_pipe_reg: RTL and testbench

// - ID/EX pipeline register. Latches decoded ID fields and the two forwarded operands
//   (rdata1/rdata2 from the ID read-operand/forwarding stage), and presents them to EX.
// - EX-result forwarding does not exist, so this block also raises the RAW interlock:
//   if an ID source register matches the destination held here, ID stalls 1 cycle.
// - Holds on stall, inserts a bubble on ID-stall/EX-run, clears on flush, counts bubbles.

---
 rtl/id_ex_pipe_reg.sv | 137 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with RAW interlock and saturating bubble counter.
// Holds decoded ID fields for EX; inserts a NOP bubble when ID stalls but EX
// runs, holds everything when EX stalls, and clears on flush.
module id_ex_pipe_reg #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       stall_i,
  input  logic             flush_i,
  input  logic [7:0]       id_aluop_i,
  input  logic [2:0]       id_alusel_i,
  input  logic [31:0]      id_reg1_i,
  input  logic [31:0]      id_reg2_i,
  input  logic [4:0]       id_waddr_i,
  input  logic             id_we_i,
  input  logic             id_is_load_i,
  input  logic [31:0]      id_inst_i,
  input  logic [31:0]      id_link_addr_i,
  input  logic             id_in_dslot_i,
  input  logic             id_next_dslot_i,
  input  logic [4:0]       id_raddr1_i,
  input  logic [4:0]       id_raddr2_i,
  input  logic             id_re1_i,
  input  logic             id_re2_i,
  output logic [7:0]       ex_aluop_o,
  output logic [2:0]       ex_alusel_o,
  output logic [31:0]      ex_reg1_o,
  output logic [31:0]      ex_reg2_o,
  output logic [4:0]       ex_waddr_o,
  output logic             ex_we_o,
  output logic             ex_is_load_o,
  output logic [31:0]      ex_inst_o,
  output logic [31:0]      ex_link_addr_o,
  output logic             ex_in_dslot_o,
  output logic             id_in_dslot_o,
  output logic             stall_req_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  waddr;
    logic        we;
    logic        is_load;
    logic [31:0] inst;
    logic [31:0] link_addr;
    logic        in_dslot;
  } ex_t;

  ex_t             id_pkt;
  ex_t             ex_d, ex_q;
  logic            dslot_d, dslot_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic            raw1, raw2;
  logic            id_stall, ex_stall;

  // Only the ID and EX stall bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5:4], stall_i[1:0]};

  assign id_stall = stall_i[2];
  assign ex_stall = stall_i[3];

  assign id_pkt = '{
    aluop:     id_aluop_i,
    alusel:    id_alusel_i,
    reg1:      id_reg1_i,
    reg2:      id_reg2_i,
    waddr:     id_waddr_i,
    we:        id_we_i,
    is_load:   id_is_load_i,
    inst:      id_inst_i,
    link_addr: id_link_addr_i,
    in_dslot:  id_in_dslot_i
  };

  // Next-state selection: flush > bubble (ID stalled, EX running) > hold > load.
  always_comb begin
    ex_d    = ex_q;
    dslot_d = dslot_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      ex_d    = '0;
      dslot_d = 1'b0;
    end else if (id_stall && !ex_stall) begin
      ex_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (ex_stall) begin
      ex_d    = ex_q;
      dslot_d = dslot_q;
    end else begin
      ex_d    = id_pkt;
      dslot_d = id_next_dslot_i;
    end
  end

  // State registers, asynchronously cleared to a NOP bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q    <= '0;
      dslot_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      dslot_q <= dslot_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAW interlock against the destination currently held for EX; $0 and
  // non-writing entries never match.
  always_comb begin
    raw1        = id_re1_i && (id_raddr1_i == ex_q.waddr);
    raw2        = id_re2_i && (id_raddr2_i == ex_q.waddr);
    stall_req_o = !rst_i && ex_q.we && (ex_q.waddr != 5'd0) && (raw1 || raw2);
  end

  assign ex_aluop_o     = ex_q.aluop;
  assign ex_alusel_o    = ex_q.alusel;
  assign ex_reg1_o      = ex_q.reg1;
  assign ex_reg2_o      = ex_q.reg2;
  assign ex_waddr_o     = ex_q.waddr;
  assign ex_we_o        = ex_q.we;
  assign ex_is_load_o   = ex_q.is_load;
  assign ex_inst_o      = ex_q.inst;
  assign ex_link_addr_o = ex_q.link_addr;
  assign ex_in_dslot_o  = ex_q.in_dslot;
  assign id_in_dslot_o  = dslot_q;
  assign bubble_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed steps then random stimulus against a
// behavioural model. A second instance with a 2-bit counter covers saturation.
module tb_id_ex_pipe_reg;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic [7:0]  id_aluop_i = '0;
  logic [2:0]  id_alusel_i = '0;
  logic [31:0] id_reg1_i = '0, id_reg2_i = '0, id_inst_i = '0, id_link_addr_i = '0;
  logic [4:0]  id_waddr_i = '0, id_raddr1_i = '0, id_raddr2_i = '0;
  logic        id_we_i = 1'b0, id_is_load_i = 1'b0, id_in_dslot_i = 1'b0, id_next_dslot_i = 1'b0;
  logic        id_re1_i = 1'b0, id_re2_i = 1'b0;

  logic [7:0]  ex_aluop_o, ex_aluop_b;
  logic [2:0]  ex_alusel_o, ex_alusel_b;
  logic [31:0] ex_reg1_o, ex_reg2_o, ex_inst_o, ex_link_addr_o;
  logic [31:0] ex_reg1_b, ex_reg2_b, ex_inst_b, ex_link_addr_b;
  logic [4:0]  ex_waddr_o, ex_waddr_b;
  logic        ex_we_o, ex_is_load_o, ex_in_dslot_o, id_in_dslot_o, stall_req_o;
  logic        ex_we_b, ex_is_load_b, ex_in_dslot_b, id_in_dslot_b, stall_req_b;
  logic [15:0] bubble_cnt_o;
  logic [1:0]  bubble_cnt_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk_i = ~clk_i;

  id_ex_pipe_reg #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_aluop_i(id_aluop_i), .id_alusel_i(id_alusel_i), .id_reg1_i(id_reg1_i),
    .id_reg2_i(id_reg2_i), .id_waddr_i(id_waddr_i), .id_we_i(id_we_i),
    .id_is_load_i(id_is_load_i), .id_inst_i(id_inst_i), .id_link_addr_i(id_link_addr_i),
    .id_in_dslot_i(id_in_dslot_i), .id_next_dslot_i(id_next_dslot_i),
    .id_raddr1_i(id_raddr1_i), .id_raddr2_i(id_raddr2_i), .id_re1_i(id_re1_i),
    .id_re2_i(id_re2_i), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
    .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_waddr_o(ex_waddr_o),
    .ex_we_o(ex_we_o), .ex_is_load_o(ex_is_load_o), .ex_inst_o(ex_inst_o),
    .ex_link_addr_o(ex_link_addr_o), .ex_in_dslot_o(ex_in_dslot_o),
    .id_in_dslot_o(id_in_dslot_o), .stall_req_o(stall_req_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_aluop_i(id_aluop_i), .id_alusel_i(id_alusel_i), .id_reg1_i(id_reg1_i),
    .id_reg2_i(id_reg2_i), .id_waddr_i(id_waddr_i), .id_we_i(id_we_i),
    .id_is_load_i(id_is_load_i), .id_inst_i(id_inst_i), .id_link_addr_i(id_link_addr_i),
    .id_in_dslot_i(id_in_dslot_i), .id_next_dslot_i(id_next_dslot_i),
    .id_raddr1_i(id_raddr1_i), .id_raddr2_i(id_raddr2_i), .id_re1_i(id_re1_i),
    .id_re2_i(id_re2_i), .ex_aluop_o(ex_aluop_b), .ex_alusel_o(ex_alusel_b),
    .ex_reg1_o(ex_reg1_b), .ex_reg2_o(ex_reg2_b), .ex_waddr_o(ex_waddr_b),
    .ex_we_o(ex_we_b), .ex_is_load_o(ex_is_load_b), .ex_inst_o(ex_inst_b),
    .ex_link_addr_o(ex_link_addr_b), .ex_in_dslot_o(ex_in_dslot_b),
    .id_in_dslot_o(id_in_dslot_b), .stall_req_o(stall_req_b), .bubble_cnt_o(bubble_cnt_b)
  );

  // Behavioural model: what EX should be holding, plus bubble counts.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  waddr;
    logic        we;
    logic        is_load;
    logic [31:0] inst;
    logic [31:0] link;
    logic        in_dslot;
  } ex_fields_t;

  ex_fields_t  m_ex = '0;
  logic        m_dslot = 1'b0;
  int unsigned m_bubbles = 0;

  function automatic ex_fields_t id_fields();
    return '{id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_waddr_i, id_we_i,
             id_is_load_i, id_inst_i, id_link_addr_i, id_in_dslot_i};
  endfunction

  function automatic logic [146:0] dut_fields();
    return {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_waddr_o, ex_we_o,
            ex_is_load_o, ex_inst_o, ex_link_addr_o, ex_in_dslot_o};
  endfunction

  function automatic logic [146:0] sat_fields();
    return {ex_aluop_b, ex_alusel_b, ex_reg1_b, ex_reg2_b, ex_waddr_b, ex_we_b,
            ex_is_load_b, ex_inst_b, ex_link_addr_b, ex_in_dslot_b};
  endfunction

  function automatic logic model_stall_req();
    logic hit1, hit2;
    hit1 = id_re1_i && (id_raddr1_i == m_ex.waddr);
    hit2 = id_re2_i && (id_raddr2_i == m_ex.waddr);
    return !rst_i && m_ex.we && (m_ex.waddr != 0) && (hit1 || hit2);
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp16;
    logic [1:0]  exp2;
    exp16 = (m_bubbles > 65535) ? 16'hFFFF : 16'(m_bubbles);
    exp2  = (m_bubbles > 3) ? 2'd3 : 2'(m_bubbles);
    chk({tag, ".ex"}, 256'(dut_fields()), 256'(m_ex));
    chk({tag, ".dslot"}, 256'(id_in_dslot_o), 256'(m_dslot));
    chk({tag, ".sreq"}, 256'(stall_req_o), 256'(model_stall_req()));
    chk({tag, ".cnt"}, 256'(bubble_cnt_o), 256'(exp16));
    chk({tag, ".sat_ex"}, 256'(sat_fields()), 256'(m_ex));
    chk({tag, ".sat_cnt"}, 256'(bubble_cnt_b), 256'(exp2));
  endtask

  // Apply one rising edge: advance the model from the current inputs, then
  // check shortly after the edge.
  task automatic step(input string tag);
    if (rst_i) begin
      m_ex = '0; m_dslot = 1'b0; m_bubbles = 0;
    end else if (flush_i) begin
      m_ex = '0; m_dslot = 1'b0;
    end else if (stall_i[2] && !stall_i[3]) begin
      m_ex = '0; m_bubbles++;
    end else if (!stall_i[3]) begin
      m_ex = id_fields(); m_dslot = id_next_dslot_i;
    end
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  task automatic randomize_id();
    id_aluop_i      = 8'($urandom);
    id_alusel_i     = 3'($urandom);
    id_reg1_i       = $urandom;
    id_reg2_i       = $urandom;
    id_waddr_i      = 5'($urandom_range(0, 7));
    id_we_i         = 1'($urandom);
    id_is_load_i    = 1'($urandom);
    id_inst_i       = $urandom;
    id_link_addr_i  = $urandom;
    id_in_dslot_i   = 1'($urandom);
    id_next_dslot_i = 1'($urandom);
    id_raddr1_i     = ($urandom_range(0, 2) == 0) ? m_ex.waddr : 5'($urandom_range(0, 7));
    id_raddr2_i     = ($urandom_range(0, 2) == 0) ? m_ex.waddr : 5'($urandom_range(0, 7));
    id_re1_i        = 1'($urandom);
    id_re2_i        = 1'($urandom);
  endtask

  initial begin
    // Reset with nonzero inputs: outputs clear asynchronously.
    randomize_id();
    id_we_i = 1'b1; id_waddr_i = 5'd3; id_raddr1_i = 5'd3; id_re1_i = 1'b1;
    stall_i = 6'b000100;
    #1 rst_i = 1'b1;
    #1;
    check_all("rst_async");
    chk("rst_sreq", 256'(stall_req_o), 256'(0));
    step("rst_edge");
    rst_i = 1'b0;
    stall_i = '0;
    #1;
    check_all("rst_release");

    // Pass-through with one-cycle latency.
    randomize_id();
    id_aluop_i = 8'h21; id_reg1_i = 32'h1234; id_waddr_i = 5'd5; id_we_i = 1'b1;
    id_re1_i = 1'b0; id_re2_i = 1'b0;
    step("pass");
    chk("pass_aluop", 256'(ex_aluop_o), 256'(8'h21));
    chk("pass_reg1", 256'(ex_reg1_o), 256'(32'h1234));
    chk("pass_waddr", 256'(ex_waddr_o), 256'(5));
    chk("pass_we", 256'(ex_we_o), 256'(1));

    // RAW on source 1: one interlock cycle, bubble inserted, request drops.
    id_raddr1_i = 5'd5; id_re1_i = 1'b1; id_re2_i = 1'b0;
    #1;
    chk("raw_req", 256'(stall_req_o), 256'(1));
    stall_i = 6'b000111;
    step("raw_bubble");
    chk("raw_ex_zero", 256'(dut_fields()), 256'(0));
    chk("raw_cnt", 256'(bubble_cnt_o), 256'(1));
    chk("raw_req_drop", 256'(stall_req_o), 256'(0));
    stall_i = '0;

    // $0 destination never interlocks.
    id_waddr_i = 5'd0; id_we_i = 1'b1;
    step("zero_load");
    id_raddr1_i = 5'd0; id_re1_i = 1'b1;
    #1;
    chk("zero_req", 256'(stall_req_o), 256'(0));
    // Non-writing entry never interlocks.
    id_waddr_i = 5'd7; id_we_i = 1'b0;
    step("nowe_load");
    id_raddr2_i = 5'd7; id_re2_i = 1'b1; id_re1_i = 1'b0;
    #1;
    chk("nowe_req", 256'(stall_req_o), 256'(0));

    // Flush beats stall; counter unchanged.
    id_we_i = 1'b1; id_next_dslot_i = 1'b1;
    step("pre_flush");
    flush_i = 1'b1; stall_i = 6'b001111;
    step("flush");
    chk("flush_ex", 256'(dut_fields()), 256'(0));
    chk("flush_dslot", 256'(id_in_dslot_o), 256'(0));
    chk("flush_cnt", 256'(bubble_cnt_o), 256'(1));
    flush_i = 1'b0; stall_i = '0;

    // Hold for three edges while EX is stalled.
    randomize_id();
    id_next_dslot_i = 1'b1;
    step("pre_hold");
    stall_i = 6'b001100;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      step("hold");
    end
    stall_i = '0;

    // Five bubbles: 2-bit counter saturates at 3.
    stall_i = 6'b000100;
    for (int i = 0; i < 5; i++) step("bubble");
    chk("sat_cnt3", 256'(bubble_cnt_b), 256'(3));
    chk("cnt_six", 256'(bubble_cnt_o), 256'(6));
    stall_i = '0;

    // Random traffic with occasional mid-cycle asynchronous reset.
    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      randomize_id();
      r = $urandom_range(0, 9);
      stall_i = (r < 2) ? 6'b000111 : (r == 2) ? 6'b001111 : (r == 3) ? 6'b000100 : 6'b000000;
      flush_i = ($urandom_range(0, 14) == 0);
      #1;
      chk("rnd_sreq", 256'(stall_req_o), 256'(model_stall_req()));
      if ((n % 97) == 50) begin
        rst_i = 1'b1;
        m_ex = '0; m_dslot = 1'b0; m_bubbles = 0;
        #1;
        check_all("rnd_rst");
        rst_i = 1'b0;
        #1;
      end
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
